card_pair_matcher: RTL and testbench

Game-logic responder for the card click events raised by the click checker. It answers the checker's card-status queries, accepts two face-down cards per move, and compares their pair identities. It holds both cards visible for a configurable time, then removes a matched pair or hides a mismatch, while tracking pairs found, moves, and game completion. It sits between the click checker and the card renderer/score display in the 65 MHz 1024x768 pipeline.

---
 rtl/card_pair_matcher.sv | 176 +++++++++++++++++
 tb/tb_card_pair_matcher.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/card_pair_matcher.sv
// Card-pair game FSM: answers card-status queries, takes two clicks, shows both cards for SHOW_CYCLES, then removes or hides them.
// Resolution 2+SHOW_CYCLES edges after the second click; enable low freezes everything. Optional moves counter: CARD_PAIR_MATCHER_MOVES_EN.
module card_pair_matcher #(
   parameter int unsigned SHOW_CYCLES = 65_000_000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        enable,
   input  logic        new_game,
   input  logic        event_occurred,
   input  logic [3:0]  card_clicked_address,
   input  logic [3:0]  card_to_test_address,
   input  logic [35:0] card_values,
   output logic [1:0]  card_test_state,
   output logic [11:0] face_up,
   output logic [11:0] in_play,
   output logic [2:0]  pairs_found,
   output logic [7:0]  moves,
   output logic        match_pulse,
   output logic        mismatch_pulse,
   output logic        game_over
);

   typedef enum logic [2:0] {
      ST_FIRST, ST_SECOND, ST_COMPARE, ST_SHOW, ST_RESOLVE, ST_DONE
   } state_t;

   localparam int unsigned TW = 27;
   localparam logic [TW-1:0] TIMER_LOAD = TW'(SHOW_CYCLES - 1);

   state_t        state_q;
   logic [TW-1:0] timer_q;
   logic [11:0]   face_up_q;
   logic [11:0]   in_play_q;
   logic [11:0]   first_q;
   logic [11:0]   second_q;
   logic [2:0]    pairs_q;
   logic          match_q;
   logic          match_pulse_q;
   logic          mismatch_pulse_q;
   logic          game_over_q;

   logic          selectable_state;
   logic [11:0]   click_mask;
   logic [11:0]   query_mask;
   logic          evt_valid;
   logic [2:0]    id_first;
   logic [2:0]    id_second;
   logic [11:0]   pair_mask;

   assign selectable_state = (state_q == ST_FIRST) || (state_q == ST_SECOND);

   // Addresses are 1-based; out-of-range addresses map to an empty mask.
   assign click_mask = (card_clicked_address >= 4'd1 && card_clicked_address <= 4'd12)
                       ? (12'd1 << (card_clicked_address - 4'd1)) : 12'd0;
   assign query_mask = (card_to_test_address >= 4'd1 && card_to_test_address <= 4'd12)
                       ? (12'd1 << (card_to_test_address - 4'd1)) : 12'd0;

   assign evt_valid = event_occurred && selectable_state
                      && (|(click_mask & in_play_q & ~face_up_q));

   assign card_test_state = {|(query_mask & face_up_q),
                             (|(query_mask & in_play_q)) & selectable_state};

   always_comb begin
      id_first  = 3'd0;
      id_second = 3'd0;
      for (int k = 0; k < 12; k++) begin
         if (first_q[k])  id_first  = id_first  | card_values[3*k +: 3];
         if (second_q[k]) id_second = id_second | card_values[3*k +: 3];
      end
   end

   assign pair_mask = first_q | second_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q          <= ST_FIRST;
         timer_q          <= '0;
         face_up_q        <= '0;
         in_play_q        <= 12'hFFF;
         first_q          <= '0;
         second_q         <= '0;
         pairs_q          <= '0;
         match_q          <= 1'b0;
         match_pulse_q    <= 1'b0;
         mismatch_pulse_q <= 1'b0;
         game_over_q      <= 1'b0;
      end else begin
         match_pulse_q    <= 1'b0;
         mismatch_pulse_q <= 1'b0;
         if (new_game) begin
            state_q     <= ST_FIRST;
            timer_q     <= '0;
            face_up_q   <= '0;
            in_play_q   <= 12'hFFF;
            first_q     <= '0;
            second_q    <= '0;
            pairs_q     <= '0;
            match_q     <= 1'b0;
            game_over_q <= 1'b0;
         end else if (enable) begin
            case (state_q)
               ST_FIRST: begin
                  if (evt_valid) begin
                     face_up_q <= face_up_q | click_mask;
                     first_q   <= click_mask;
                     state_q   <= ST_SECOND;
                  end
               end
               ST_SECOND: begin
                  if (evt_valid) begin
                     face_up_q <= face_up_q | click_mask;
                     second_q  <= click_mask;
                     state_q   <= ST_COMPARE;
                  end
               end
               ST_COMPARE: begin
                  match_q <= (id_first == id_second);
                  timer_q <= TIMER_LOAD;
                  state_q <= ST_SHOW;
               end
               ST_SHOW: begin
                  if (timer_q == '0) state_q <= ST_RESOLVE;
                  else               timer_q <= timer_q - 1'b1;
               end
               ST_RESOLVE: begin
                  face_up_q <= face_up_q & ~pair_mask;
                  if (match_q) begin
                     in_play_q     <= in_play_q & ~pair_mask;
                     pairs_q       <= pairs_q + 3'd1;
                     match_pulse_q <= 1'b1;
                     if (pairs_q == 3'd5) begin
                        state_q     <= ST_DONE;
                        game_over_q <= 1'b1;
                     end else begin
                        state_q <= ST_FIRST;
                     end
                  end else begin
                     mismatch_pulse_q <= 1'b1;
                     state_q          <= ST_FIRST;
                  end
               end
               ST_DONE: state_q <= ST_DONE;
               default: state_q <= ST_FIRST;
            endcase
         end
      end
   end

`ifdef CARD_PAIR_MATCHER_MOVES_EN
   logic [7:0] moves_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         moves_q <= '0;
      end else if (new_game) begin
         moves_q <= '0;
      end else if (enable && state_q == ST_COMPARE && moves_q != 8'hFF) begin
         moves_q <= moves_q + 8'd1;
      end
   end

   assign moves = moves_q;
`else
   assign moves = 8'd0;
`endif

   assign face_up        = face_up_q;
   assign in_play        = in_play_q;
   assign pairs_found    = pairs_q;
   assign match_pulse    = match_pulse_q;
   assign mismatch_pulse = mismatch_pulse_q;
   assign game_over      = game_over_q;

endmodule

// File: tb/tb_card_pair_matcher.sv
// Scoreboard bench for card_pair_matcher: stimulus queues expected resolutions, a monitor checks them on each pulse.
module tb_card_pair_matcher;

   localparam int S = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        enable;
   logic        new_game;
   logic        event_occurred;
   logic [3:0]  card_clicked_address;
   logic [3:0]  card_to_test_address;
   logic [35:0] card_values;
   logic [1:0]  card_test_state;
   logic [11:0] face_up;
   logic [11:0] in_play;
   logic [2:0]  pairs_found;
   logic [7:0]  moves;
   logic        match_pulse;
   logic        mismatch_pulse;
   logic        game_over;

   always #5 clk = ~clk;

   card_pair_matcher #(.SHOW_CYCLES(S)) dut (
      .clk                  (clk),
      .rst_n                (rst_n),
      .enable               (enable),
      .new_game             (new_game),
      .event_occurred       (event_occurred),
      .card_clicked_address (card_clicked_address),
      .card_to_test_address (card_to_test_address),
      .card_values          (card_values),
      .card_test_state      (card_test_state),
      .face_up              (face_up),
      .in_play              (in_play),
      .pairs_found          (pairs_found),
      .moves                (moves),
      .match_pulse          (match_pulse),
      .mismatch_pulse       (mismatch_pulse),
      .game_over            (game_over)
   );

   typedef struct {
      bit          is_match;
      int          cyc;
      logic [11:0] fu;
      logic [11:0] ip;
      logic [2:0]  pf;
      logic [7:0]  mv;
      logic        go;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] em(input int n);
`ifdef CARD_PAIR_MATCHER_MOVES_EN
      return 8'(n);
`else
      return 8'd0;
`endif
   endfunction

   function automatic exp_t mk(input bit m, input int c, input logic [11:0] fu,
                               input logic [11:0] ip, input logic [2:0] pf,
                               input logic [7:0] mv, input logic go);
      exp_t e;
      e.is_match = m; e.cyc = c; e.fu = fu; e.ip = ip; e.pf = pf; e.mv = mv; e.go = go;
      return e;
   endfunction

   // Monitor: every resolution pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      exp_t e;
      if (match_pulse === 1'b1 || mismatch_pulse === 1'b1) begin
         if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_pulse: got match=%b mismatch=%b expected none at cyc %0d",
                     match_pulse, mismatch_pulse, cyc);
         end else begin
            e = q.pop_front();
            chk("pulse_kind", {30'd0, match_pulse, mismatch_pulse}, e.is_match ? 32'd2 : 32'd1);
            chk("resolve_cycle", cyc, e.cyc);
            chk("res_face_up", face_up, e.fu);
            chk("res_in_play", in_play, e.ip);
            chk("res_pairs", pairs_found, e.pf);
            chk("res_moves", moves, e.mv);
            chk("res_game_over", game_over, e.go);
         end
      end
   end

   task automatic click(input logic [3:0] a, output int e);
      @(posedge clk); #1;
      event_occurred       = 1'b1;
      card_clicked_address = a;
      @(posedge clk); #1;
      e                    = cyc;
      event_occurred       = 1'b0;
   endtask

   task automatic query(input logic [3:0] a, input logic [1:0] exp, input string name);
      card_to_test_address = a;
      #1;
      chk(name, card_test_state, exp);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      int e, tmp, a, b;
      rst_n = 1'b0; enable = 1'b1; new_game = 1'b0; event_occurred = 1'b0;
      card_clicked_address = 4'd0; card_to_test_address = 4'd0;
      for (int k = 0; k < 12; k++) card_values[3*k +: 3] = 3'(k / 2);

      repeat (2) @(posedge clk); #1;
      chk("rst_in_play", in_play, 12'hFFF);
      chk("rst_face_up", face_up, 12'h000);
      chk("rst_pairs", pairs_found, 3'd0);
      chk("rst_moves", moves, 8'd0);
      chk("rst_game_over", game_over, 1'b0);
      chk("rst_pulses", {match_pulse, mismatch_pulse}, 2'b00);
      for (int i = 0; i < 16; i++)
         query(4'(i), (i >= 1 && i <= 12) ? 2'b01 : 2'b00, "rst_query");
      rst_n = 1'b1;

      // Move 1: match 1,2
      click(4'd1, e);
      chk("first_visible", face_up, 12'h001);
      click(4'd2, e);
      chk("both_visible", face_up, 12'h003);
      q.push_back(mk(1, e + S + 2, 12'h000, 12'hFFC, 3'd1, em(1), 1'b0));
      repeat (S + 4) @(posedge clk);

      // Move 2: mismatch 3,5, queries during SHOW
      click(4'd3, e);
      click(4'd5, e);
      q.push_back(mk(0, e + S + 2, 12'h000, 12'hFFC, 3'd1, em(2), 1'b0));
      @(posedge clk); #1;
      for (int i = 1; i <= 12; i++)
         query(4'(i), (i == 3 || i == 5) ? 2'b10 : 2'b00, "show_query");
      repeat (S + 4) @(posedge clk);

      // Move 3: ignored events, then match 3,4 with a click during SHOW
      click(4'd3, e);
      chk("sel_first", face_up, 12'h004);
      click(4'd3, tmp);  chk("reclick_ignored", face_up, 12'h004);
      click(4'd0, tmp);  chk("addr0_ignored", face_up, 12'h004);
      click(4'd13, tmp); chk("addr13_ignored", face_up, 12'h004);
      click(4'd1, tmp);  chk("removed_ignored", face_up, 12'h004);
      chk("ignored_in_play", in_play, 12'hFFC);
      click(4'd4, e);
      q.push_back(mk(1, e + S + 2, 12'h000, 12'hFF0, 3'd2, em(3), 1'b0));
      click(4'd5, tmp);
      chk("show_click_ignored", face_up, 12'h00C);
      repeat (S + 4) @(posedge clk);

      // Moves 4..7: clear the board
      for (int m = 0; m < 4; m++) begin
         a = 5 + 2 * m;
         b = a + 1;
         click(4'(a), e);
         click(4'(b), e);
         q.push_back(mk(1, e + S + 2, 12'h000, 12'hFFF << b, 3'(3 + m), em(4 + m), m == 3));
         repeat (S + 4) @(posedge clk);
      end
      #1;
      chk("done_game_over", game_over, 1'b1);
      chk("done_pairs", pairs_found, 3'd6);
      query(4'd1, 2'b00, "done_query");

      // new_game together with an event
      @(posedge clk); #1;
      new_game = 1'b1; event_occurred = 1'b1; card_clicked_address = 4'd1;
      @(posedge clk); #1;
      new_game = 1'b0; event_occurred = 1'b0;
      chk("ng_in_play", in_play, 12'hFFF);
      chk("ng_face_up", face_up, 12'h000);
      chk("ng_pairs", pairs_found, 3'd0);
      chk("ng_moves", moves, 8'd0);
      chk("ng_game_over", game_over, 1'b0);
      query(4'd1, 2'b01, "ng_query");

      // enable low for 10 cycles mid-SHOW
      click(4'd1, e);
      click(4'd3, e);
      q.push_back(mk(0, e + S + 2 + 10, 12'h000, 12'hFFF, 3'd0, em(1), 1'b0));
      repeat (2) @(posedge clk); #1;
      enable = 1'b0;
      repeat (10) @(posedge clk); #1;
      chk("frozen_face_up", face_up, 12'h005);
      enable = 1'b1;
      repeat (S + 4) @(posedge clk);

      // asynchronous reset mid-SHOW
      click(4'd2, e);
      click(4'd4, e);
      repeat (2) @(posedge clk); #1;
      chk("pre_rst_face_up", face_up, 12'h00A);
      #3;
      rst_n = 1'b0;
      #1;
      chk("arst_face_up", face_up, 12'h000);
      chk("arst_in_play", in_play, 12'hFFF);
      chk("arst_pairs", pairs_found, 3'd0);
      chk("arst_moves", moves, 8'd0);
      chk("arst_game_over", game_over, 1'b0);
      query(4'd1, 2'b01, "arst_query");
      #20;
      rst_n = 1'b1;
      repeat (S + 6) @(posedge clk);

      for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
      total++;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL pending_resolutions: got %0d outstanding expected 0", q.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
